// File: rtl/uart_csr_arbiter.sv
// uart_csr_arbiter: round-robin sharing of the UART core CSR port between two requesters
module uart_csr_arbiter #(
    parameter int ADD_WIDTH = 8
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 m0_req,
    input  logic                 m0_wr,
    input  logic [ADD_WIDTH-1:0] m0_addr,
    input  logic [31:0]          m0_wdata,
    output logic                 m0_ack,
    output logic [31:0]          m0_rdata,
    input  logic                 m1_req,
    input  logic                 m1_wr,
    input  logic [ADD_WIDTH-1:0] m1_addr,
    input  logic [31:0]          m1_wdata,
    output logic                 m1_ack,
    output logic [31:0]          m1_rdata,
    output logic [ADD_WIDTH-1:0] csr_addr,
    output logic [31:0]          csr_wr_data,
    output logic                 csr_rd,
    output logic                 csr_wr,
    input  logic [31:0]          csr_rd_data,
    output logic                 busy,
    output logic                 grant
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, ACK} state_t;
    state_t               state_q, state_d;
    logic                 grant_q, grant_d, last_q, last_d, wr_q, wr_d;
    logic                 csr_rd_q, csr_rd_d, csr_wr_q, csr_wr_d;
    logic                 m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
    logic [31:0]          m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic [31:0]          csr_wr_data_q, csr_wr_data_d;
    logic [ADD_WIDTH-1:0] csr_addr_q, csr_addr_d;
    logic                 any_req, win, start, capt, sel_wr;
    assign any_req = m0_req | m1_req;
    // state and datapath registers; reset drops any in-flight access
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            grant_q       <= 1'b0;
            last_q        <= 1'b1;
            wr_q          <= 1'b0;
            csr_rd_q      <= 1'b0;
            csr_wr_q      <= 1'b0;
            m0_ack_q      <= 1'b0;
            m1_ack_q      <= 1'b0;
            m0_rdata_q    <= '0;
            m1_rdata_q    <= '0;
            csr_addr_q    <= '0;
            csr_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_q        <= last_d;
            wr_q          <= wr_d;
            csr_rd_q      <= csr_rd_d;
            csr_wr_q      <= csr_wr_d;
            m0_ack_q      <= m0_ack_d;
            m1_ack_q      <= m1_ack_d;
            m0_rdata_q    <= m0_rdata_d;
            m1_rdata_q    <= m1_rdata_d;
            csr_addr_q    <= csr_addr_d;
            csr_wr_data_q <= csr_wr_data_d;
        end
    end
    // IDLE waits for a request, then ISSUE, CAPT and ACK each last exactly one cycle
    always_comb begin
        state_d = (state_q == IDLE && !any_req) ? IDLE : state_t'(state_q + 2'd1);
    end
    // winner selection, request latching, strobes, read capture and ack generation
    always_comb begin
        win           = (m0_req & m1_req) ? ~last_q : m1_req;
        start         = (state_q == IDLE) & any_req;
        capt          = (state_q == CAPT);
        sel_wr        = win ? m1_wr : m0_wr;
        grant_d       = start ? win : grant_q;
        wr_d          = start ? sel_wr : wr_q;
        csr_addr_d    = start ? (win ? m1_addr : m0_addr) : csr_addr_q;
        csr_wr_data_d = start ? (win ? m1_wdata : m0_wdata) : csr_wr_data_q;
        csr_rd_d      = start & ~sel_wr;
        csr_wr_d      = start & sel_wr;
        m0_ack_d      = capt & ~grant_q;
        m1_ack_d      = capt & grant_q;
        m0_rdata_d    = (capt & ~grant_q & ~wr_q) ? csr_rd_data : m0_rdata_q;
        m1_rdata_d    = (capt & grant_q & ~wr_q) ? csr_rd_data : m1_rdata_q;
        last_d        = (state_q == ACK) ? grant_q : last_q;
    end
    assign m0_ack      = m0_ack_q;
    assign m1_ack      = m1_ack_q;
    assign m0_rdata    = m0_rdata_q;
    assign m1_rdata    = m1_rdata_q;
    assign csr_addr    = csr_addr_q;
    assign csr_wr_data = csr_wr_data_q;
    assign csr_rd      = csr_rd_q;
    assign csr_wr      = csr_wr_q;
    assign busy        = (state_q != IDLE);
    assign grant       = grant_q;
endmodule

// File: doc/uart_csr_arbiter.md
# uart_csr_arbiter

Two-port round-robin arbiter that shares the single bram-style CSR port of the UART core between two requesters, e.g. the AXI-lite slave bridge and an on-chip console/debug engine. It sits between the requesters and the core's `addr/wdata/rdata/rden/wren` port. It serialises their accesses into one-cycle read/write strobes that match the core's one-cycle read latency, and returns read data and a completion acknowledge to the winning requester.

## Interface
- `ADD_WIDTH`, 8, CSR byte-address width; matches the UART core address port.
- `aclk`  in  1  single clock; all logic rising-edge.
- `aresetn`  in  1  asynchronous, active-low reset.
- `m0_req`, `m1_req`  in  1 each  request. Held high, together with addr/wr/wdata, until ack.
- `m0_wr`, `m1_wr`  in  1 each  1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  ADD_WIDTH each  CSR address.
- `m0_wdata`, `m1_wdata`  in  32 each  write data.
- `m0_ack`, `m1_ack`  out  1 each  one-cycle completion pulse, registered.
- `m0_rdata`, `m1_rdata`  out  32 each  read data, registered; valid while ack is high.
- `csr_addr`  out  ADD_WIDTH  to core `addr`, registered.
- `csr_wr_data`  out  32  to core `wdata`, registered.
- `csr_rd`  out  1  to core `rden`, one-cycle pulse.
- `csr_wr`  out  1  to core `wren`, one-cycle pulse.
- `csr_rd_data`  in  32  from core `rdata`; valid the cycle after `csr_rd`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `grant`  out  1  index of the current or most recent winner.

## Operation
- FSM has four states: IDLE → ISSUE → CAPT → ACK → IDLE, one cycle each, with no waiting in ISSUE/CAPT/ACK.
- IDLE:
  - If any `mN_req` is sampled high, select a winner, latch its addr/wdata/wr into the `csr_*` registers, set `csr_rd = ~wr` and `csr_wr = wr`, and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: the strobe is high for this cycle only and cleared at the edge. Go to CAPT.
- CAPT:
  - For a read, `m<grant>_rdata <= csr_rd_data`. For a write, rdata is unchanged.
  - `m<grant>_ack <= 1`. Go to ACK.
- ACK: ack is high. At the edge, ack is cleared, `last <= grant`, and the FSM goes to IDLE.
- Arbitration:
  - A single request is granted directly.
  - When both request, the winner is `~last`.
  - `last` resets to 1, so requester 0 wins the first contention.
  - Requests are sampled only in IDLE. A request rising during ISSUE/CAPT/ACK waits.
- Fairness: a requester waiting in IDLE is served no later than after one transaction of the other requester. Worst-case req→ack is 7 cycles.
- Only the granted requester's ack/rdata change. The other requester's rdata holds its value.
- `csr_addr` and `csr_wr_data` hold their last values after the transaction. Only the strobes return low.
- Request inputs are not re-sampled after the grant. Changing addr/wdata before ack has no effect on the current transaction.
- Reset values:
  - state = IDLE.
  - All acks, `csr_rd`, `csr_wr`, and `busy` = 0.
  - All rdata, `csr_addr`, and `csr_wr_data` = 0.
  - `grant` = 0; `last` = 1.
- Reset asserted mid-transaction: all outputs go to their reset values immediately (asynchronously). The in-flight access is dropped with no ack. If the strobe was already issued, the core has seen it.

## Timing
- Request sampled at edge E0 (IDLE). Then:
  - E0 → E1: `csr_rd`/`csr_wr` high.
  - E1 → E2: core rdata is valid and captured at E2.
  - E2 → E3: ack high.
- Request-to-ack latency is 3 cycles after the sampling edge. Peak throughput is one access per 4 cycles.
- A requester that sees ack at E3 may hold req high for a new access. It is sampled in IDLE at E4. Deasserting req at E3 ends cleanly, with no duplicate access.
- Exactly one `csr_rd` or `csr_wr` pulse occurs per granted request. The two strobes are never high together.
- `busy` is high from the cycle after the sampling edge through the ACK cycle inclusive.

## Test plan
- **Single read:** m0 reads addr 0x04 while the core model returns 0xA5A5_0001 → exactly one `csr_rd` pulse with `csr_addr` = 0x04; `m0_ack` 3 cycles after sampling; `m0_rdata` = 0xA5A5_0001; `m1_ack` stays 0.
- **Single write:** m1 writes 0x0000_0041 to addr 0x00 → exactly one `csr_wr` pulse with `csr_wr_data` = 0x41; `m1_ack` pulses; `m1_rdata` unchanged; `csr_rd` never high.
- **Simultaneous requests:** both request reads, with continuous re-requesting after each ack, over 6 transactions → grants alternate 0,1,0,1,0,1, starting with 0 after reset; every ack is a 1-cycle pulse, 4 cycles apart.
- **Back-to-back same requester:** m0 holds req through 3 accesses while m1 rises during m0's ISSUE → the order is m0, m1, m0; m1's ack is no more than 7 cycles after its req rises.
- **Reset mid-operation:** `aresetn` asserted during CAPT of a read → ack never pulses; all outputs are 0 immediately; after release, a new m1 request completes normally with `last` = 1 behaviour (m0 wins the next contention).
- **Input change after grant:** m0 changes addr from 0x08 to 0x0C during ISSUE → `csr_addr` stays 0x08 for the whole transaction.
